abs_diff_err_monitor: RTL

//  Sequential stimulus/checker stage for approximate abs_diff circuits (SOP/XPAT netlists).

---
 rtl/abs_diff_err_monitor.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/abs_diff_err_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : abs_diff_err_monitor
//  Description : Exhaustive sweep driver and error checker for an approximate
//                combinational |a-b| circuit; reports worst/total error,
//                threshold violations and a pass/fail verdict.
//  Revision    : 1.0 - initial release
// ============================================================================
module abs_diff_err_monitor #(
    parameter int W_OP = 2,
    parameter int ET   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [2*W_OP-1:0]   dut_in,
    input  logic [W_OP-1:0]     dut_out,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [W_OP-1:0]     max_err,
    output logic [3*W_OP-1:0]   err_sum,
    output logic [2*W_OP:0]     viol_cnt,
    output logic [2*W_OP-1:0]   first_viol_vec,
    output logic                first_viol_valid
);

    localparam logic [2*W_OP-1:0] c_LAST = '1;
    localparam logic [W_OP:0]     c_ET   = (W_OP+1)'(ET);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_armed;
    logic [2*W_OP-1:0]   r_dut_in;
    logic [2*W_OP-1:0]   r_s1_vec;
    logic [W_OP-1:0]     r_s1_apx;
    logic                r_s1_valid;
    logic [W_OP-1:0]     r_max_err;
    logic [3*W_OP-1:0]   r_err_sum;
    logic [2*W_OP:0]     r_viol_cnt;
    logic [2*W_OP-1:0]   r_first_viol_vec;
    logic                r_first_viol_valid;

    logic                w_accept;
    logic [W_OP:0]       w_diff;
    logic [W_OP:0]       w_diff_neg;
    logic [W_OP-1:0]     w_exact;
    logic [W_OP:0]       w_edif;
    logic [W_OP:0]       w_edif_neg;
    logic [W_OP-1:0]     w_err;
    logic                w_viol;

    // r_armed keeps a start that coincides with reset release from being taken
    assign w_accept = start && r_armed && (r_state == S_IDLE || r_state == S_DONE);

    always_comb begin
        w_diff     = {1'b0, r_s1_vec[W_OP-1:0]} - {1'b0, r_s1_vec[2*W_OP-1:W_OP]};
        w_diff_neg = -w_diff;
        w_exact    = w_diff[W_OP] ? w_diff_neg[W_OP-1:0] : w_diff[W_OP-1:0];
        w_edif     = {1'b0, r_s1_apx} - {1'b0, w_exact};
        w_edif_neg = -w_edif;
        w_err      = w_edif[W_OP] ? w_edif_neg[W_OP-1:0] : w_edif[W_OP-1:0];
        w_viol     = ({1'b0, w_err} > c_ET);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SWEEP;
            S_SWEEP: if (r_dut_in == c_LAST) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  if (w_accept) w_state_nxt = S_SWEEP;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed            <= 1'b0;
            r_dut_in           <= '0;
            r_s1_vec           <= '0;
            r_s1_apx           <= '0;
            r_s1_valid         <= 1'b0;
            r_max_err          <= '0;
            r_err_sum          <= '0;
            r_viol_cnt         <= '0;
            r_first_viol_vec   <= '0;
            r_first_viol_valid <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_accept) begin
                r_dut_in           <= '0;
                r_s1_valid         <= 1'b0;
                r_max_err          <= '0;
                r_err_sum          <= '0;
                r_viol_cnt         <= '0;
                r_first_viol_vec   <= '0;
                r_first_viol_valid <= 1'b0;
            end else begin
                if (r_s1_valid) begin
                    if (w_err > r_max_err) r_max_err <= w_err;
                    r_err_sum <= r_err_sum + {{(2*W_OP){1'b0}}, w_err};
                    if (w_viol) begin
                        r_viol_cnt <= r_viol_cnt + (2*W_OP+1)'(1);
                        if (!r_first_viol_valid) begin
                            r_first_viol_vec   <= r_s1_vec;
                            r_first_viol_valid <= 1'b1;
                        end
                    end
                end
                if (r_state == S_SWEEP) begin
                    r_s1_vec   <= r_dut_in;
                    r_s1_apx   <= dut_out;
                    r_s1_valid <= 1'b1;
                    r_dut_in   <= r_dut_in + (2*W_OP)'(1);
                end else if (r_state == S_DRAIN) begin
                    r_s1_valid <= 1'b0;
                end
            end
        end
    end

    assign dut_in           = r_dut_in;
    assign busy             = (r_state == S_SWEEP) || (r_state == S_DRAIN);
    assign done             = (r_state == S_DONE);
    assign pass             = done && ({1'b0, r_max_err} <= c_ET);
    assign max_err          = r_max_err;
    assign err_sum          = r_err_sum;
    assign viol_cnt         = r_viol_cnt;
    assign first_viol_vec   = r_first_viol_vec;
    assign first_viol_valid = r_first_viol_valid;

endmodule
`default_nettype wire
